aud_i2s_recorder: RTL and testbench
===================================

// Module: aud_i2s_recorder
// PURPOSE
//  - I2S capture stage upstream of sample storage: deserialises WM8731 ADC stream (ADCDAT/ADCLRCK), keeps left channel only.
//  - Emits one 16-bit sample per LRCK frame with a write strobe and linear 20-bit SRAM address.
//  - Driven by the top-level FSM through start/pause/stop. Runs in the BCLK domain beside the DSP/player pair.
// PARAMETERS
//  DATA_W    16        sample width; bits shifted per left frame
//  ADDR_W    20        storage address width
//  MAX_ADDR  20'hFFFFF last writable address; recording stops after writing it
// PORTS
//  i_clk      in   1       sole clock (AUD_BCLK). All logic samples on posedge.
//  i_rst      in   1       synchronous, active-high reset
//  i_start    in   1       start or resume request, level or pulse
//  i_pause    in   1       pause request
//  i_stop     in   1       stop request
//  i_lrc      in   1       ADCLRCK; low = left channel
//  i_data     in   1       ADCDAT, MSB first
//  o_address  out  ADDR_W  write address of current/next sample
//  o_data     out  DATA_W  captured sample, valid while o_we=1
//  o_we       out  1       one-cycle write strobe
//  o_len      out  ADDR_W  samples written since last start-from-idle
//  o_full     out  1       high in S_FULL
//  o_busy     out  1       high in any state except S_IDLE
// BEHAVIOUR
//  - Reset, effective at the next posedge:
//    - state=S_IDLE.
//    - o_address, o_data, o_len, o_we, o_full, o_busy all =0.
//    - lrc_d=1 and bit_cnt=0.
//    - A reset mid-record drops any partial sample and does not raise o_we.
//  - lrc_d holds i_lrc delayed by one cycle. frame_start = lrc_d & ~i_lrc.
//  - All outputs are registered. o_we is high only in S_WRITE.
//  - Request priority each cycle: stop > pause > start.
//  - FSM:
//    - S_IDLE:
//      - i_start -> S_WAIT. Clear o_address and o_len on this edge.
//    - S_WAIT:
//      - frame_start -> S_SHIFT with bit_cnt=0.
//      - The detect edge is the I2S one-BCLK delay slot; no bit is captured on it.
//    - S_SHIFT:
//      - Each cycle: shreg <= {shreg[DATA_W-2:0], i_data}; bit_cnt++.
//      - When bit_cnt==DATA_W-1 -> S_WRITE, loading o_data with the completed word.
//      - Right-channel bits and bits beyond DATA_W are ignored.
//    - S_WRITE (exactly 1 cycle):
//      - o_we=1, o_address = the address of this sample.
//      - On exit: o_len++.
//      - If o_address==MAX_ADDR -> S_FULL, o_address holds.
//      - Else o_address++ and -> S_WAIT.
//    - S_PAUSE:
//      - o_address and o_len hold.
//      - i_start -> S_WAIT. Resume waits for a fresh frame_start.
//    - S_FULL:
//      - o_full=1, no further writes.
//      - Only i_stop leaves, -> S_IDLE.
//  - Pause:
//    - i_pause in S_WAIT or S_SHIFT -> S_PAUSE, partial word discarded.
//    - i_pause in S_WRITE: the write completes, then -> S_PAUSE instead of S_WAIT.
//  - Stop:
//    - i_stop in any non-idle state -> S_IDLE.
//    - If it arrives in S_WRITE, that write still occurs and is counted in o_len.
//    - o_len holds in S_IDLE until the next start.
//  - i_start while recording (S_WAIT/S_SHIFT/S_WRITE) is ignored.
//  - Address wrap-around never occurs: saturation at MAX_ADDR goes via S_FULL.
//  - Latency: o_we rises on the cycle after the posedge that samples the LSB. That is 17 cycles after the frame_start edge.
// STRUCTURE
//  - Shared package aud_pkg:
//    - rec_state_t enum: S_IDLE, S_WAIT, S_SHIFT, S_WRITE, S_PAUSE, S_FULL.
//    - AUD_DATA_W=16 and AUD_ADDR_W=20, shared with DSP/player.
//  - Sub-module aud_i2s_deser:
//    - Contains the lrc_d edge detect, shift register and bit counter.
//    - Outputs a word_valid pulse and the word.
//    - Controlled by a clear input, driven high outside S_WAIT/S_SHIFT.
//  - The FSM, address counter and length counter stay in this module.
// TESTING
//  1. Apply reset, then drive 40 BCLKs of random lrc/data with no start.
//     Required: o_we, o_busy and o_address stay 0 throughout.
//  2. Pulse start, then send a left word 16'hA5C3 and a right word 16'h1234.
//     Required: one o_we with o_data=16'hA5C3, o_address=0, 17 cycles after the LRCK fall.
//     Afterwards o_address=1 and o_len=1.
//  3. Record 3 frames, pause in the middle of the 4th frame's shift, then start again.
//     Required: the partial word is never written.
//     The next word lands at address 3 on the following left frame.
//  4. Run with MAX_ADDR=4 and 6 frames.
//     Required: 5 writes at addresses 0..4, o_full=1, o_address=4.
//     Frames 6+ are ignored; a stop then gives o_busy=0 and o_len=5.
//  5. Assert stop in the S_WRITE cycle of sample 2.
//     Required: that write is seen (address 2), o_len=3, state returns to S_IDLE.
//     A new start clears o_len to 0.
//  6. Assert i_rst on bit 8 of a frame.
//     Required: no o_we occurs, all outputs are 0 next cycle, and a new start records from address 0.

Source files
------------

// File: rtl/aud_pkg.sv
// aud_pkg: shared audio widths and recorder state encoding
package aud_pkg;
  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHIFT, S_WRITE, S_PAUSE, S_FULL} rec_state_t;
endpackage

// File: rtl/aud_i2s_recorder_if.sv
// aud_i2s_recorder_if: control, I2S input and storage-write bus of the recorder
interface aud_i2s_recorder_if import aud_pkg::*; #(
  parameter int DATA_W = AUD_DATA_W,
  parameter int ADDR_W = AUD_ADDR_W
);
  logic i_start, i_pause, i_stop, i_lrc, i_data;
  logic [ADDR_W-1:0] o_address, o_len;
  logic [DATA_W-1:0] o_data;
  logic o_we, o_full, o_busy;
  modport master (output i_start, i_pause, i_stop, i_lrc, i_data,
                  input o_address, o_len, o_data, o_we, o_full, o_busy);
  modport slave  (input i_start, i_pause, i_stop, i_lrc, i_data,
                  output o_address, o_len, o_data, o_we, o_full, o_busy);
endinterface

// File: rtl/aud_i2s_deser.sv
// aud_i2s_deser: LRCK fall detect and MSB-first left-word shifter, held idle by clear
module aud_i2s_deser import aud_pkg::*; #(
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic              o_frame_start,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);
  localparam int CW = $clog2(DATA_W);
  logic lrc_q, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-2:0] sh_q, sh_d;
  assign o_frame_start = lrc_q & ~i_lrc;
  assign o_word = {sh_q, i_data};
  assign o_word_valid = armed_q && cnt_q == CW'(DATA_W - 1);
  // Arming on the fall edge itself skips the I2S one-BCLK delay slot
  always_comb begin
    armed_d = i_clear ? 1'b0 : armed_q ? ~o_word_valid : o_frame_start;
    cnt_d = (i_clear || !armed_q) ? '0 : cnt_q + 1'b1;
    sh_d = armed_q ? o_word[DATA_W-2:0] : sh_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lrc_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      lrc_q <= i_lrc;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/aud_i2s_recorder.sv
// aud_i2s_recorder: left-channel I2S capture with start/pause/stop control and linear storage addressing
module aud_i2s_recorder import aud_pkg::*; #(
  parameter int                DATA_W   = AUD_DATA_W,
  parameter int                ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input logic i_clk,
  input logic i_rst,
  aud_i2s_recorder_if.slave bus
);
  rec_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d, word;
  logic we_q, we_d, full_q, full_d, busy_q, busy_d;
  logic clear, frame_start, word_valid, at_max;
  assign clear = !(state_q == S_WAIT || state_q == S_SHIFT);
  assign at_max = addr_q == MAX_ADDR;
  aud_i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (clear),
    .i_lrc         (bus.i_lrc),
    .i_data        (bus.i_data),
    .o_frame_start (frame_start),
    .o_word_valid  (word_valid),
    .o_word        (word)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    case (state_q)
      S_IDLE: if (bus.i_start) begin
        state_d = S_WAIT;
        addr_d = '0;
        len_d = '0;
      end
      S_WAIT:  state_d = bus.i_stop ? S_IDLE : bus.i_pause ? S_PAUSE : frame_start ? S_SHIFT : S_WAIT;
      S_SHIFT: state_d = bus.i_stop ? S_IDLE : bus.i_pause ? S_PAUSE : word_valid ? S_WRITE : S_SHIFT;
      // The write always completes; stop or pause only choose where it goes next
      S_WRITE: begin
        len_d = len_q + 1'b1;
        addr_d = at_max ? addr_q : addr_q + 1'b1;
        state_d = bus.i_stop ? S_IDLE : at_max ? S_FULL : bus.i_pause ? S_PAUSE : S_WAIT;
      end
      S_PAUSE: state_d = bus.i_stop ? S_IDLE : bus.i_pause ? S_PAUSE : bus.i_start ? S_WAIT : S_PAUSE;
      S_FULL:  state_d = bus.i_stop ? S_IDLE : S_FULL;
      default: state_d = S_IDLE;
    endcase
    data_d = state_d == S_WRITE ? word : data_q;
    we_d = state_d == S_WRITE;
    full_d = state_d == S_FULL;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      len_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      full_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      data_q <= data_d;
      we_q <= we_d;
      full_q <= full_d;
      busy_q <= busy_d;
    end
  end
  assign bus.o_address = addr_q;
  assign bus.o_len = len_q;
  assign bus.o_data = data_q;
  assign bus.o_we = we_q;
  assign bus.o_full = full_q;
  assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_aud_i2s_recorder.sv
// tb_aud_i2s_recorder: random I2S frames and control pulses against a frame-level recorder model with a write scoreboard
module tb_aud_i2s_recorder;
  localparam logic [19:0] MAXA = 20'd4;
  typedef enum {EV_NONE, EV_START, EV_PAUSE, EV_STOP, EV_RST} ev_t;
  typedef struct {logic [19:0] a; logic [15:0] d; int t;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  aud_i2s_recorder_if bus();
  aud_i2s_recorder #(.MAX_ADDR(MAXA)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, errs = 0;
  exp_t q[$];
  exp_t e;
  int m_addr = 0, m_len = 0;
  bit m_busy = 0, m_rec = 0, m_full = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Behavioural model: one left word per frame while recording, saturating at MAXA
  function automatic void m_start();
    if (!m_busy) begin
      m_busy = 1; m_rec = 1; m_full = 0; m_addr = 0; m_len = 0;
    end else if (!m_rec && !m_full) m_rec = 1;
  endfunction
  function automatic void m_pause();
    m_rec = 0;
  endfunction
  function automatic void m_stop();
    m_busy = 0; m_rec = 0; m_full = 0;
  endfunction
  function automatic void m_reset();
    m_stop(); m_addr = 0; m_len = 0;
  endfunction
  function automatic void m_frame(input logic [15:0] d, input int t);
    if (m_rec) begin
      q.push_back('{20'(m_addr), d, t});
      m_len++;
      if (20'(m_addr) == MAXA) begin m_full = 1; m_rec = 0; end
      else m_addr++;
    end
  endfunction

  always @(negedge clk) if (bus.o_we === 1'b1) begin
    if (q.size() == 0) begin
      vecs++; errs++;
      $display("FAIL spurious_we: got addr %0h data %0h, want no write (cycle %0d)", bus.o_address, bus.o_data, cyc);
    end else begin
      e = q.pop_front();
      chk("we_addr", bus.o_address, e.a);
      chk("we_data", bus.o_data, e.d);
      chk("we_latency", cyc, e.t);
    end
  end

  task automatic drv(input logic lrc, d, st, pa, sp, rs);
    @(negedge clk);
    bus.i_lrc = lrc; bus.i_data = d; bus.i_start = st; bus.i_pause = pa; bus.i_stop = sp; rst = rs;
  endtask
  task automatic idle_cyc(input int n);
    repeat (n) drv(1'b1, 1'($urandom), 0, 0, 0, 0);
  endtask
  task automatic pulse(input ev_t k);
    drv(1'b1, 1'($urandom), k == EV_START, k == EV_PAUSE, k == EV_STOP, 0);
    if (k == EV_START) m_start();
    if (k == EV_PAUSE) m_pause();
    if (k == EV_STOP) m_stop();
  endtask
  task automatic chk_state(input string n);
    chk({n, "_addr"}, bus.o_address, m_addr);
    chk({n, "_len"}, bus.o_len, m_len);
    chk({n, "_full"}, bus.o_full, m_full);
    chk({n, "_busy"}, bus.o_busy, m_busy);
  endtask
  // 18-cycle left half (slot, 16 bits, filler) then 18-cycle right half
  task automatic send_frame(input logic [15:0] l, r, input int ev_idx = -1, input ev_t ev = EV_NONE);
    logic d;
    for (int i = 0; i < 36; i++) begin
      d = (i >= 1 && i <= 16) ? l[16-i] : (i >= 19 && i <= 34) ? r[34-i] : 1'($urandom);
      drv(i >= 18, d, ev == EV_START && i == ev_idx, ev == EV_PAUSE && i == ev_idx,
          ev == EV_STOP && i == ev_idx, ev == EV_RST && i == ev_idx);
      if (i == 0) m_frame(l, cyc + 17);
      if (ev == EV_RST && i == ev_idx + 1)
        chk("rst_mid_outputs", {bus.o_address, bus.o_data, bus.o_len, bus.o_we, bus.o_full, bus.o_busy}, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    bus.i_start = 0; bus.i_pause = 0; bus.i_stop = 0; bus.i_lrc = 1; bus.i_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.o_address, bus.o_data, bus.o_len, bus.o_we, bus.o_full, bus.o_busy}, 0);
    m_reset();
    for (int i = 0; i < 40; i++) begin
      drv(1'($urandom), 1'($urandom), 0, 0, 0, 0);
      chk("no_start_idle", {bus.o_we, bus.o_busy, bus.o_address}, 0);
    end
    idle_cyc(2);
    pulse(EV_START);
    send_frame(16'hA5C3, 16'h1234);
    idle_cyc(2);
    chk_state("first_word");
    pulse(EV_STOP); pulse(EV_START);
    repeat (3) send_frame(16'($urandom), 16'($urandom));
    m_pause();
    send_frame(16'($urandom), 16'($urandom), 9, EV_PAUSE);
    idle_cyc(2);
    chk_state("paused");
    pulse(EV_START);
    send_frame(16'($urandom), 16'($urandom));
    idle_cyc(2);
    chk_state("resumed");
    pulse(EV_STOP); pulse(EV_START);
    repeat (6) send_frame(16'($urandom), 16'($urandom));
    idle_cyc(2);
    chk_state("full");
    pulse(EV_STOP);
    idle_cyc(2);
    chk_state("full_stopped");
    pulse(EV_START);
    repeat (2) send_frame(16'($urandom), 16'($urandom));
    send_frame(16'($urandom), 16'($urandom), 17, EV_STOP);
    m_stop();
    idle_cyc(2);
    chk_state("stop_in_write");
    pulse(EV_START);
    idle_cyc(1);
    chk_state("restart_clears");
    m_reset();
    send_frame(16'($urandom), 16'($urandom), 8, EV_RST);
    idle_cyc(2);
    chk_state("after_reset");
    pulse(EV_START);
    send_frame(16'($urandom), 16'($urandom));
    idle_cyc(2);
    chk_state("reset_restart");
    pulse(EV_STOP); pulse(EV_START);
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 4);
      if (r == 0) begin
        pulse(EV_PAUSE);
        send_frame(16'($urandom), 16'($urandom));
        pulse(EV_START);
      end else if (r == 1) begin
        pulse(EV_STOP);
        idle_cyc(1);
        chk_state("rand_stop");
        pulse(EV_START);
      end else send_frame(16'($urandom), 16'($urandom));
    end
    idle_cyc(20);
    chk_state("rand_end");
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
